regfile_reader: RTL and testbench
=================================

// Module: regfile_reader
// PURPOSE
//   8-entry bank of 32-bit write-enabled registers plus a sequential readout engine.
//   A start pulse makes the engine stream a run of consecutive entries out over a
//   valid/ready handshake.
//   Acts as the reader end for register writes; feeds the dump/debug path.
// PARAMETERS
//   WIDTH   32  data width of every entry
//   DEPTH   8   number of entries (power of two)
//   ADDR_W  3   log2(DEPTH)
// PORTS
//   clk          in   1          rising-edge clock; the only clock
//   reset        in   1          synchronous, active-low; 0 = reset
//   wr_enable    in   1          write strobe
//   wr_addr      in   ADDR_W     write address
//   wr_data      in   WIDTH      write data
//   rd_start     in   1          one-cycle request to begin a readout
//   rd_first     in   ADDR_W     first entry of the run
//   rd_count     in   ADDR_W+1   number of words in the run (0..DEPTH)
//   rd_ready     in   1          consumer accepts rd_data this cycle
//   rd_valid     out  1          rd_data/rd_addr hold a word
//   rd_data      out  WIDTH      word being presented
//   rd_addr      out  ADDR_W     entry index of rd_data
//   rd_last      out  1          presented word is the final word of the run
//   busy         out  1          engine is not IDLE
//   done         out  1          one-cycle pulse when the run completes
// BEHAVIOUR
//   - Reset (reset==0 at posedge):
//     - all entries, rd_data and rd_addr go to 0
//     - rd_valid, rd_last, busy and done go to 0; FSM goes to IDLE
//     - takes effect mid-run as well; any word in flight is dropped
//   - Write: at posedge, wr_enable=1 sets entry[wr_addr] <= wr_data; no read latency.
//   - FSM states: IDLE, SEND, DONE.
//   - IDLE:
//     - on posedge with rd_start=1 and rd_count!=0: latch ptr=rd_first, rem=rd_count
//     - on the same edge: load rd_data=entry[rd_first], rd_addr=rd_first, rd_valid=1,
//       rd_last=(rd_count==1); go to SEND
//     - first word therefore appears 1 cycle after the start edge
//     - rd_start with rd_count==0: go to DONE directly; no word is presented
//   - SEND, handshake = rd_valid & rd_ready at posedge:
//     - without a handshake: rd_data, rd_addr and rd_last hold stable
//     - handshake with rem==1: rd_valid <= 0, go to DONE
//     - handshake with rem>1: ptr <= (ptr+1) mod DEPTH (wraps 7->0), rem <= rem-1;
//       next word is loaded on the same edge and rd_valid stays 1
//     - back-to-back throughput: 1 word/cycle
//   - DONE: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
//   - busy=1 only in SEND.
//   - rd_start is ignored while in SEND or DONE.
//   - Write/read collision: when a word is loaded on the same edge as a write to
//     the same entry, the loaded word is the new wr_data (write forwarding).
//   - Snapshot rule: a word already on rd_data is not changed by later writes to
//     its entry.
//   - rd_count > DEPTH is illegal; behaviour is undefined.
// TESTING
//   1. Write entry[i]=10*i for i=0..7, then rd_start with first=2, count=3, ready=1:
//      -> words 20,30,40 on consecutive cycles; rd_last set on 40; done 1 cycle later.
//   2. first=6, count=4 -> addrs 6,7,0,1, data 60,70,0,10; checks wrap-around.
//   3. count=2 with rd_ready held 0 for 5 cycles -> rd_data stays 20 and rd_valid
//      stays 1 throughout; the stream resumes when ready rises.
//   4. Start on entry 3 while the same cycle writes entry3=100 -> first word is 100.
//      Writing entry3=200 while it is presented -> rd_data stays 100.
//   5. count=0 -> no rd_valid, done pulses 1 cycle after the start edge.
//      rd_start during SEND is ignored and the run length is unchanged.
//   6. reset=0 mid-run -> next cycle all outputs 0, FSM IDLE, a read of entry 5
//      returns 0, and writes after reset=1 behave normally.

Source files
------------

// File: rtl/regfile_reader.sv
// regfile_reader
//   Bank of DEPTH write-enabled WIDTH-bit registers plus a readout engine.
//   One rd_start pulse streams rd_count consecutive entries, starting at
//   rd_first and wrapping modulo DEPTH, over a valid/ready handshake.
//
//   state | meaning
//   ------+---------------------------------------------------
//   IDLE  | waiting for rd_start
//   SEND  | a word is presented on rd_data, waiting for rd_ready
//   DONE  | run finished; done pulses for this one cycle
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous reset, active low
//   wr_enable  write strobe; entry[wr_addr] <= wr_data
//   wr_addr    write address
//   wr_data    write data
//   rd_start   one-cycle request to begin a run (honoured in IDLE only)
//   rd_first   first entry of the run
//   rd_count   words in the run (0..DEPTH)
//   rd_ready   consumer accepts the presented word
//   rd_valid   rd_data/rd_addr hold a word
//   rd_data    presented word (snapshot taken when it was loaded)
//   rd_addr    entry index of rd_data
//   rd_last    presented word is the final word of the run
//   busy       engine is in SEND
//   done       one-cycle completion pulse
module regfile_reader #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_enable,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_first,
  input  logic [ADDR_W:0]   rd_count,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ZERO = '0;
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_TWO  = (ADDR_W+1)'(2);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W:0]   rem;
  logic              handshake;
  logic              start_run;
  logic [ADDR_W-1:0] load_addr;
  logic [WIDTH-1:0]  load_word;

  assign handshake = rd_valid & rd_ready;
  assign start_run = rd_start && (rd_count != CNT_ZERO);

  // rd_addr doubles as the run pointer; the increment wraps naturally
  // because DEPTH is a power of two.
  assign load_addr = (state == S_IDLE) ? rd_first : rd_addr + ADDR_ONE;

  // A write landing on the entry being loaded this edge is forwarded so the
  // streamed word reflects the newest value.
  assign load_word = (wr_enable && (wr_addr == load_addr)) ? wr_data : mem[load_addr];

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (rd_start) state_nxt = (rd_count != CNT_ZERO) ? S_SEND : S_DONE;
      end
      S_SEND: begin
        if (handshake && (rem == CNT_ONE)) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_SEND);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_addr  <= '0;
      rd_last  <= 1'b0;
      rem      <= '0;
    end else begin
      if (wr_enable) mem[wr_addr] <= wr_data;
      case (state)
        S_IDLE: begin
          if (start_run) begin
            rem      <= rd_count;
            rd_data  <= load_word;
            rd_addr  <= load_addr;
            rd_valid <= 1'b1;
            rd_last  <= (rd_count == CNT_ONE);
          end
        end
        S_SEND: begin
          if (handshake) begin
            if (rem == CNT_ONE) begin
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
            end else begin
              rem     <= rem - CNT_ONE;
              rd_data <= load_word;
              rd_addr <= load_addr;
              rd_last <= (rem == CNT_TWO);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_reader.sv
// Bench for regfile_reader: directed scenarios plus randomized runs, all
// checked against a plain array model of the register contents and a queue
// of the words a run must deliver.
module tb_regfile_reader;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_enable;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_start;
  logic [ADDR_W-1:0] rd_first;
  logic [ADDR_W:0]   rd_count;
  logic              rd_ready;
  logic              rd_valid;
  logic [WIDTH-1:0]  rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_last;
  logic              busy;
  logic              done;

  regfile_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_enable (wr_enable),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_start  (rd_start),
    .rd_first  (rd_first),
    .rd_count  (rd_count),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_addr   (rd_addr),
    .rd_last   (rd_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] ref_mem [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [31:0] d);
    wr_enable = 1'b1;
    wr_addr   = a[ADDR_W-1:0];
    wr_data   = d;
    step();
    wr_enable = 1'b0;
    ref_mem[a] = d;
  endtask

  // Issue one run and follow it to completion. The expected stream is the
  // model contents of entries first, first+1, ... (mod DEPTH). ready is held
  // low for stall_first cycles, then dropped with probability stall_pct%.
  // With poke set, a second rd_start is fired mid-run and must be ignored.
  task automatic do_run(input int first, input int count, input int stall_pct,
                        input int stall_first, input bit poke);
    int          q_addr[$];
    logic [31:0] q_data[$];
    int          cyc = 0;
    int          stalls = 0;
    int          stall_left = stall_first;
    bit          fin = 0;
    bit          rdy;
    for (int k = 0; k < count; k++) begin
      q_addr.push_back((first + k) % DEPTH);
      q_data.push_back(ref_mem[(first + k) % DEPTH]);
    end
    rd_first = first[ADDR_W-1:0];
    rd_count = count[ADDR_W:0];
    rd_start = 1'b1;
    rd_ready = 1'b0;
    step();
    rd_start = 1'b0;
    while (!fin && cyc < 100) begin
      cyc++;
      if (q_addr.size() == 0) begin
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("valid_at_done", {31'd0, rd_valid}, 32'd0);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("run_cycles", cyc, count + stalls + 1);
        fin = 1;
      end else begin
        chk("valid", {31'd0, rd_valid}, 32'd1);
        chk("busy", {31'd0, busy}, 32'd1);
        chk("done_early", {31'd0, done}, 32'd0);
        chk("addr", {29'd0, rd_addr}, q_addr[0]);
        chk("data", rd_data, q_data[0]);
        chk("last", {31'd0, rd_last}, (q_addr.size() == 1) ? 32'd1 : 32'd0);
        if (stall_left > 0) begin
          rdy = 1'b0;
          stall_left--;
        end else begin
          rdy = ($urandom_range(99) >= stall_pct);
        end
        rd_ready = rdy;
        if (rdy) begin
          void'(q_addr.pop_front());
          void'(q_data.pop_front());
        end else begin
          stalls++;
        end
        if (poke && cyc == 2) begin
          rd_start = 1'b1;
          rd_first = ADDR_W'($urandom_range(DEPTH - 1));
          rd_count = 4'd8;
        end else begin
          rd_start = 1'b0;
        end
        step();
      end
    end
    if (!fin) chk("run_timeout", 32'd0, 32'd1);
    rd_ready = 1'b0;
    rd_start = 1'b0;
    step();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_valid", {31'd0, rd_valid}, 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    wr_enable = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_start  = 1'b0;
    rd_first  = '0;
    rd_count  = '0;
    rd_ready  = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    step();
    step();
    chk("rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_data", rd_data, 32'd0);
    chk("rst_addr", {29'd0, rd_addr}, 32'd0);
    chk("rst_last", {31'd0, rd_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    step();

    // Basic run, wrap-around, and a stalled consumer.
    for (int i = 0; i < DEPTH; i++) write_word(i, 32'(10 * i));
    do_run(2, 3, 0, 0, 0);
    do_run(6, 4, 0, 0, 0);
    do_run(2, 2, 0, 5, 0);

    // Write forwarding on the start edge, then snapshot stability.
    wr_enable = 1'b1;
    wr_addr   = 3'd3;
    wr_data   = 32'd100;
    rd_start  = 1'b1;
    rd_first  = 3'd3;
    rd_count  = 4'd1;
    rd_ready  = 1'b0;
    ref_mem[3] = 32'd100;
    step();
    rd_start = 1'b0;
    wr_data  = 32'd200;
    step();
    wr_enable = 1'b0;
    ref_mem[3] = 32'd200;
    chk("fwd_valid", {31'd0, rd_valid}, 32'd1);
    chk("fwd_data", rd_data, 32'd100);
    chk("fwd_addr", {29'd0, rd_addr}, 32'd3);
    chk("fwd_last", {31'd0, rd_last}, 32'd1);
    step();
    chk("snap_data", rd_data, 32'd100);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("fwd_done", {31'd0, done}, 32'd1);
    chk("fwd_valid_off", {31'd0, rd_valid}, 32'd0);
    step();
    do_run(3, 1, 0, 0, 0);

    // Empty run and an ignored mid-run start.
    do_run(0, 0, 0, 0, 0);
    do_run(1, 5, 0, 0, 1);
    do_run(7, 8, 30, 0, 1);

    // Reset in the middle of a run.
    rd_start = 1'b1;
    rd_first = 3'd5;
    rd_count = 4'd4;
    rd_ready = 1'b1;
    step();
    rd_start = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("mid_rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("mid_rst_data", rd_data, 32'd0);
    chk("mid_rst_addr", {29'd0, rd_addr}, 32'd0);
    chk("mid_rst_last", {31'd0, rd_last}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    reset    = 1'b1;
    rd_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    step();
    do_run(5, 1, 0, 0, 0);
    write_word(5, 32'h0000_5555);
    do_run(4, 3, 0, 0, 0);

    // Randomized contents, run shapes and consumer back-pressure.
    for (int i = 0; i < DEPTH; i++) write_word(i, $urandom);
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(2) == 0) write_word($urandom_range(DEPTH - 1), $urandom);
      do_run($urandom_range(DEPTH - 1), $urandom_range(DEPTH), $urandom_range(60), 0,
             1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
